// File: rtl/ram_access_arbiter_if.sv
// Bundle of the CPU, loader and RAM-side signals around the RAM access arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_mfc;

  logic              ldr_req;
  logic              ldr_rw;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_wdata;
  logic [7:0]        ldr_rdata;
  logic              ldr_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  logic              busy;
  logic              grant_ldr;

  modport slave (
    input  cpu_req, cpu_rw, cpu_size, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_mfc,
    input  ldr_req, ldr_rw, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy, grant_ldr
  );

  modport master (
    output cpu_req, cpu_rw, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_mfc,
    output ldr_req, ldr_rw, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy, grant_ldr
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares one byte-wide RAM port between the CPU (byte/half/word, big-endian beats, MFC)
// and the loader/debug port (single bytes), with round-robin arbitration on ties.
module ram_access_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input logic                  Clock,
  input logic                  Clear,
  ram_access_arbiter_if.slave  bus
);

  localparam int WCNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    WAIT,
    DONE
  } state_t;

  state_t            state, state_nx;

  logic              owner_ldr;
  logic              last_ldr;
  logic              rw_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        beat_q;
  logic [1:0]        last_beat_q;
  logic [31:0]       wsh_q;
  logic [31:0]       acc_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [31:0]       cpu_rdata_q;
  logic [7:0]        ldr_rdata_q;

  logic              any_req;
  logic              pick_ldr;
  logic              beat_last;
  logic              wait_last;

  assign any_req   = bus.cpu_req || bus.ldr_req;
  // Loader wins unless the CPU is also asking and the loader owned the previous access.
  assign pick_ldr  = bus.ldr_req && (!bus.cpu_req || !last_ldr);
  assign beat_last = (beat_q == last_beat_q);
  assign wait_last = (wcnt_q == WCNT_W'(RAM_LAT - 1));

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.cpu_mfc   = 1'b0;
    bus.ldr_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = BEAT;
        end
      end
      BEAT: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = !rw_q;
        bus.ram_addr  = base_q + ADDR_W'(beat_q);
        bus.ram_wdata = wsh_q[31:24];
        if (rw_q) begin
          state_nx = WAIT;
        end else if (beat_last) begin
          state_nx = DONE;
        end else begin
          state_nx = BEAT;
        end
      end
      WAIT: begin
        if (wait_last) begin
          state_nx = beat_last ? DONE : BEAT;
        end
      end
      DONE: begin
        bus.cpu_mfc = !owner_ldr;
        bus.ldr_ack = owner_ldr;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.grant_ldr = owner_ldr && (state != IDLE);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      owner_ldr   <= 1'b0;
      last_ldr    <= 1'b0;
      rw_q        <= 1'b0;
      base_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      wsh_q       <= '0;
      acc_q       <= '0;
      wcnt_q      <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_ldr <= pick_ldr;
            beat_q    <= '0;
            acc_q     <= '0;
            wcnt_q    <= '0;
            if (pick_ldr) begin
              rw_q        <= bus.ldr_rw;
              base_q      <= bus.ldr_addr;
              last_beat_q <= 2'd0;
              wsh_q       <= {bus.ldr_wdata, 24'h0};
            end else begin
              rw_q   <= bus.cpu_rw;
              base_q <= bus.cpu_addr;
              // Write data is left-justified so every beat takes the top byte.
              case (bus.cpu_size)
                2'b00: begin
                  last_beat_q <= 2'd0;
                  wsh_q       <= {bus.cpu_wdata[7:0], 24'h0};
                end
                2'b01: begin
                  last_beat_q <= 2'd1;
                  wsh_q       <= {bus.cpu_wdata[15:0], 16'h0};
                end
                default: begin
                  last_beat_q <= 2'd3;
                  wsh_q       <= bus.cpu_wdata;
                end
              endcase
            end
          end
        end
        BEAT: begin
          if (!rw_q) begin
            wsh_q  <= {wsh_q[23:0], 8'h0};
            beat_q <= beat_q + 2'd1;
          end else begin
            wcnt_q <= '0;
          end
        end
        WAIT: begin
          if (wait_last) begin
            acc_q  <= {acc_q[23:0], bus.ram_rdata};
            beat_q <= beat_q + 2'd1;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        DONE: begin
          last_ldr <= owner_ldr;
          if (rw_q) begin
            if (owner_ldr) begin
              ldr_rdata_q <= acc_q[7:0];
            end else begin
              cpu_rdata_q <= acc_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
